// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared definitions for the 5-bit sequence checker: width,
//                seed and fixed-point constants, the next-state function and
//                the checker state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int                LFSR_W     = 5;
    localparam logic [LFSR_W-1:0] LFSR_SEED  = 5'b11111;
    // 00000 maps onto itself, so it can never prove the stream is alive.
    localparam logic [LFSR_W-1:0] ZERO_STATE = 5'b00000;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_nx(input logic [LFSR_W-1:0] v);
        logic [LFSR_W-1:0] n;
        n[0] = v[3];
        n[1] = v[0];
        n[2] = v[1];
        n[3] = v[2] | v[4];
        n[4] = v[3] ^ v[4];
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_next.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_next
//  Description : Combinational next-state of the 5-bit sequence generator.
//  Ports       : i_v  - current value
//                o_nx - value the generator produces after i_v
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_next
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] i_v,
    output logic [LFSR_W-1:0] o_nx
);

    assign o_nx = lfsr_nx(i_v);

endmodule
`default_nettype wire

// File: rtl/lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_seq_checker
//  Description : Self-check stage behind the 5-bit sequence generator.
//                SEARCH: learns the stream from consecutive samples and locks
//                after LOCK_CNT correct transitions. LOCKED: free-runs its own
//                prediction (flywheel), flags each deviating sample and falls
//                back to SEARCH after UNLOCK_CNT consecutive deviations.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                din       - generator sample
//                din_valid - din qualifier; nothing changes while low
//                err_clr   - synchronous clear of err_cnt
//                locked    - high while in LOCKED
//                err       - one-cycle pulse per mismatch while LOCKED
//                err_cnt   - saturating mismatch count
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] din,
    input  logic              din_valid,
    input  logic              err_clr,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [3:0] c_lock   = 4'(LOCK_CNT);
    localparam logic [3:0] c_unlock = 4'(UNLOCK_CNT);

    state_e             r_state,  w_state_nx;
    logic [LFSR_W-1:0]  r_prev,   w_prev_nx;
    logic               r_pvld,   w_pvld_nx;
    logic [LFSR_W-1:0]  r_exp,    w_exp_nx;
    logic [3:0]         r_good,   w_good_nx;
    logic [3:0]         r_bad,    w_bad_nx;
    logic               r_err,    w_err_nx;
    logic [ERR_W-1:0]   r_err_cnt, w_cnt_nx;

    logic [LFSR_W-1:0]  w_nx_prev;
    logic [LFSR_W-1:0]  w_nx_exp;
    logic               w_search_hit;

    lfsr_next u_nx_prev (
        .i_v  (r_prev),
        .o_nx (w_nx_prev)
    );

    lfsr_next u_nx_exp (
        .i_v  (r_exp),
        .o_nx (w_nx_exp)
    );

    // A zero sample would "predict" itself forever, so it never counts.
    assign w_search_hit = r_pvld && (din == w_nx_prev) && (din != ZERO_STATE);

    always_comb begin
        w_state_nx = r_state;
        w_prev_nx  = r_prev;
        w_pvld_nx  = r_pvld;
        w_exp_nx   = r_exp;
        w_good_nx  = r_good;
        w_bad_nx   = r_bad;
        w_err_nx   = 1'b0;
        w_cnt_nx   = r_err_cnt;

        if (din_valid) begin
            case (r_state)
                SEARCH: begin
                    w_prev_nx = din;
                    w_pvld_nx = 1'b1;
                    w_good_nx = w_search_hit ? (r_good + 4'd1) : 4'd0;
                    if (w_good_nx == c_lock) begin
                        w_state_nx = LOCKED;
                        w_exp_nx   = lfsr_nx(din);
                        w_bad_nx   = 4'd0;
                    end
                end
                LOCKED: begin
                    // Prediction advances unconditionally so one corrupted
                    // sample costs exactly one error.
                    w_exp_nx = w_nx_exp;
                    if (din != r_exp) begin
                        w_err_nx = 1'b1;
                        w_bad_nx = r_bad + 4'd1;
                        if (r_err_cnt != {ERR_W{1'b1}}) begin
                            w_cnt_nx = r_err_cnt + 1'b1;
                        end
                    end else begin
                        w_bad_nx = 4'd0;
                    end
                    if (w_bad_nx == c_unlock) begin
                        w_state_nx = SEARCH;
                        w_good_nx  = 4'd0;
                        w_prev_nx  = din;
                        w_pvld_nx  = 1'b1;
                    end
                end
                default: w_state_nx = SEARCH;
            endcase
        end

        if (err_clr) begin
            w_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= SEARCH;
            r_prev    <= '0;
            r_pvld    <= 1'b0;
            r_exp     <= '0;
            r_good    <= 4'd0;
            r_bad     <= 4'd0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_prev    <= w_prev_nx;
            r_pvld    <= w_pvld_nx;
            r_exp     <= w_exp_nx;
            r_good    <= w_good_nx;
            r_bad     <= w_bad_nx;
            r_err     <= w_err_nx;
            r_err_cnt <= w_cnt_nx;
        end
    end

    assign locked  = (r_state == LOCKED);
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_seq_checker
//  Description : Self-checking bench for lfsr_seq_checker. Two instances share
//                stimulus: default ERR_W=8 and ERR_W=2 for saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_seq_checker;

    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 3;

    logic       clk = 1'b1;
    logic       rst;
    logic [4:0] din;
    logic       din_valid;
    logic       err_clr;
    logic       locked,  err;
    logic [7:0] err_cnt;
    logic       locked2, err2;
    logic [1:0] err_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lfsr_seq_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .err_clr(err_clr),
        .locked(locked), .err(err), .err_cnt(err_cnt)
    );

    lfsr_seq_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .err_clr(err_clr),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2)
    );

    // ---------------- reference model ----------------
    bit       m_locked;
    bit [4:0] m_prev, m_exp;
    bit       m_pvld;
    int       m_good, m_bad;
    bit       m_err;
    int       m_cnt8, m_cnt2;
    logic [4:0] gen;   // last correct generator value driven

    function automatic logic [4:0] nx(input logic [4:0] v);
        return {v[3] ^ v[4], v[2] | v[4], v[1], v[0], v[3]};
    endfunction

    task automatic m_reset();
        m_locked = 0; m_prev = 0; m_exp = 0; m_pvld = 0;
        m_good = 0; m_bad = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic m_update(input logic [4:0] d, input logic v, input logic c);
        m_err = 0;
        if (v) begin
            if (!m_locked) begin
                if (m_pvld && d == nx(m_prev) && d != 5'd0) m_good++;
                else m_good = 0;
                m_prev = d; m_pvld = 1;
                if (m_good == LOCK_CNT) begin
                    m_locked = 1; m_exp = nx(d); m_bad = 0;
                end
            end else begin
                if (d != m_exp) begin
                    m_err = 1;
                    m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                    m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
                    m_bad++;
                end else begin
                    m_bad = 0;
                end
                m_exp = nx(m_exp);
                if (m_bad == UNLOCK_CNT) begin
                    m_locked = 0; m_good = 0; m_prev = d; m_pvld = 1;
                end
            end
        end
        if (c) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},   32'(locked),   32'(m_locked));
        check({tag, ".err"},      32'(err),      32'(m_err));
        check({tag, ".err_cnt"},  32'(err_cnt),  32'(m_cnt8));
        check({tag, ".locked2"},  32'(locked2),  32'(m_locked));
        check({tag, ".err_cnt2"}, 32'(err_cnt2), 32'(m_cnt2));
    endtask

    task automatic step(input string tag, input logic [4:0] d, input logic v, input logic c);
        din = d; din_valid = v; err_clr = c;
        @(posedge clk);
        m_update(d, v, c);
        #1;
        check_all(tag);
    endtask

    task automatic drive_good(input string tag);
        gen = nx(gen);
        step(tag, gen, 1'b1, 1'b0);
    endtask

    // Advances the generator but delivers a corrupted copy.
    task automatic drive_bad(input string tag, input logic c);
        logic [4:0] mask;
        gen  = nx(gen);
        mask = 5'($urandom_range(1, 31));
        step(tag, gen ^ mask, 1'b1, c);
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; err_clr = 1'b0;
        m_reset();

        // 1. reset held 25 units with din toggling
        #4;
        for (int i = 0; i < 5; i++) begin
            din = 5'($urandom); din_valid = 1'($urandom);
            #1 check_all("reset_hold");
            #4;
        end
        #1 rst = 1'b0; din_valid = 1'b0;
        for (int i = 0; i < 3; i++) step("idle_after_rst", 5'($urandom), 1'b0, 1'b0);

        // 2. lock acquisition
        step("lock0", 5'b00001, 1'b1, 1'b0);
        gen = 5'b00001;
        for (int i = 0; i < 4; i++) drive_good("lock_seq");
        check("lock_reached", 32'(locked), 32'd1);

        // 3. single error: expected 11010 then 01101
        gen = nx(gen);
        step("single_err", 5'b11011, 1'b1, 1'b0);
        check("single_err_pulse", 32'(err), 32'd1);
        drive_good("after_err");
        check("after_err_gen", 32'(gen), 32'b01101);
        drive_good("after_err2");

        // 4. loss of lock and relock
        for (int i = 0; i < 3; i++) drive_bad("unlock", 1'b0);
        check("unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 6; i++) drive_good("relock");

        // 5. stuck-zero, then period-2 lock and ERR_W=2 saturation
        for (int i = 0; i < 20; i++) step("stuck_zero", 5'b00000, 1'b1, 1'b0);
        gen = 5'b01111;
        for (int i = 0; i < 6; i++) drive_good("period2");
        check("period2_locked", 32'(locked), 32'd1);
        for (int r = 0; r < 3; r++) begin
            drive_bad("sat_bad", 1'b0);
            if (r < 2) drive_bad("sat_bad", 1'b0);
            drive_good("sat_good");
        end
        check("sat_cnt2", 32'(err_cnt2), 32'd3);
        drive_bad("clr_with_err", 1'b1);
        check("clr_cnt", 32'(err_cnt), 32'd0);
        drive_good("after_clr");

        // 6. gaps: idle cycles must not advance the prediction
        for (int i = 0; i < 8; i++) begin
            drive_good("gap_valid");
            step("gap_idle", 5'($urandom), 1'b0, 1'($urandom_range(0, 7) == 0));
        end

        // randomized mix
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step("rnd_idle", 5'($urandom), 1'b0, 1'($urandom_range(0, 29) == 0));
            end else if ($urandom_range(0, 9) == 0) begin
                drive_bad("rnd_bad", 1'($urandom_range(0, 29) == 0));
            end else begin
                drive_good("rnd_good");
            end
        end

        // asynchronous reset while locked
        for (int i = 0; i < 8; i++) drive_good("pre_rst");
        drive_bad("pre_rst_err", 1'b0);
        #3 rst = 1'b1;
        #1;
        m_reset();
        check_all("async_rst");
        check("async_rst_locked", 32'(locked), 32'd0);
        #2 rst = 1'b0;
        drive_good("post_rst_first");
        for (int i = 0; i < 4; i++) drive_good("post_rst_relock");
        check("post_rst_locked", 32'(locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
